dma_controller: RTL and testbench

Single-channel DMA engine for the cpu/ram/io system. It sits between the io device and the ram bus and moves a block of WSZ-bit words between io and a contiguous ram region. It obtains the bus from the cpu with a hold request/acknowledge handshake and releases it when the block is finished. The cpu programs it through a small register port.

---
 rtl/dma_controller.sv | 136 +++++++++++++
 tb/tb_dma_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// Single-channel DMA engine: moves a block of words between the io device and a
// contiguous ram region while holding the bus granted by the cpu.
module dma_controller #(
  parameter int unsigned SZ  = 8,
  parameter int unsigned WSZ = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [1:0]     cfg_addr,
  input  logic [SZ-1:0]  cfg_wdata,
  output logic           busy,
  output logic           done,
  output logic           hold_req,
  input  logic           hold_ack,
  output logic [SZ-1:0]  ram_addr,
  output logic           ram_w_notr,
  output logic [WSZ-1:0] ram_wdata,
  input  logic [WSZ-1:0] ram_rdata,
  input  logic           io_req,
  output logic           io_ack,
  input  logic [WSZ-1:0] io_rdata,
  output logic [WSZ-1:0] io_wdata
);

  typedef enum logic [2:0] {
    StIdle, StHold, StRd, StWaitIo, StWr, StAck, StNext, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [SZ-1:0]  base_q, base_d;
  logic [SZ-1:0]  count_q, count_d;
  logic [SZ-1:0]  addr_q, addr_d;
  logic [SZ-1:0]  cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic [WSZ-1:0] buf_q, buf_d;
  logic           cfg_ok;
  logic           start;

  assign busy   = (state_q != StIdle) && (state_q != StDone);
  assign cfg_ok = cfg_we && !busy;
  assign start  = cfg_ok && (cfg_addr == 2'd2) && cfg_wdata[0];

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    if (cfg_ok) begin
      case (cfg_addr)
        2'd0:    base_d  = cfg_wdata;
        2'd1:    count_d = cfg_wdata;
        2'd2:    dir_d   = cfg_wdata[1];
        default: ;
      endcase
    end

    // Every bus-owning state only advances while the grant is present, so a lost
    // grant freezes the FSM in place.
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          addr_d  = base_q;
          cnt_d   = count_q;
          state_d = (count_q == '0) ? StDone : StHold;
        end
      end
      StHold: begin
        if (hold_ack) state_d = dir_q ? StRd : StWaitIo;
      end
      StRd: begin
        if (hold_ack) begin
          buf_d   = ram_rdata;
          state_d = StWaitIo;
        end
      end
      StWaitIo: begin
        if (hold_ack && io_req) begin
          if (!dir_q) begin
            buf_d   = io_rdata;
            state_d = StWr;
          end else begin
            state_d = StAck;
          end
        end
      end
      StWr, StAck: begin
        if (hold_ack) state_d = StNext;
      end
      StNext: begin
        if (hold_ack) begin
          addr_d = addr_q + SZ'(1);
          cnt_d  = cnt_q - SZ'(1);
          if (cnt_q == SZ'(1)) state_d = StDone;
          else                 state_d = dir_q ? StRd : StWaitIo;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign hold_req  = busy;
  assign done      = (state_q == StDone);
  assign ram_addr  = addr_q;
  assign ram_wdata = buf_q;
  assign io_wdata  = buf_q;
  // The live grant gates the strobes so nothing is driven after the cpu takes the bus back.
  assign ram_w_notr = (state_q == StWr) && hold_ack;
  assign io_ack     = ((state_q == StWr) || (state_q == StAck)) && hold_ack;

endmodule

// File: tb/tb_dma_controller.sv
// Randomised scoreboard bench for dma_controller: a block-level model predicts ram
// writes, io deliveries and done pulses; a negedge monitor pops and compares them.
module tb_dma_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic       busy, done, hold_req, hold_ack;
  logic [7:0] ram_addr, ram_wdata, ram_rdata, io_rdata, io_wdata;
  logic       ram_w_notr, io_req, io_ack;

  dma_controller #(.SZ(8), .WSZ(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .busy(busy), .done(done), .hold_req(hold_req), .hold_ack(hold_ack),
    .ram_addr(ram_addr), .ram_w_notr(ram_w_notr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata),
    .io_wdata(io_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_io [$];
  bit          exp_done [$];
  logic [7:0]  io_src [$];
  logic [7:0]  fixed_q [$];
  int          io_rd = 0;
  int          io_ack_cnt = 0;
  int          ack_base = 0;
  bit          io_en = 1'b0;
  bit          io_saw;
  bit          cur_dir = 1'b0;
  int          gmode = 0;
  bit          man_ack = 1'b0;
  logic [7:0]  m_base = 8'd0;
  logic [7:0]  m_count = 8'd0;
  bit          m_dir = 1'b0;
  bit          m_busy = 1'b0;
  int          m_n = 0;

  assign ram_rdata = mem[ram_addr];

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h20) return 8'h5C;
    if (i == 'h21) return 8'h5D;
    return 8'((i * 37 + 11) & 255);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(input string name, input int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, none expected", name, act);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench ram plus scoreboard monitor.
  initial begin
    logic [15:0] e;
    for (int i = 0; i < 256; i++) mem[i] = init_val(i);
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!hold_ack) begin
          chk("ram_w_notr_without_grant", ram_w_notr, 0);
          chk("io_ack_without_grant", io_ack, 0);
        end
        if (ram_w_notr) begin
          mem[ram_addr] = ram_wdata;
          if (exp_wr.size() == 0) fail("unexpected_ram_write_addr", int'(ram_addr));
          else begin
            e = exp_wr.pop_front();
            chk("ram_write_addr", ram_addr, e[15:8]);
            chk("ram_write_data", ram_wdata, e[7:0]);
          end
        end
        if (io_ack) begin
          io_ack_cnt++;
          if (cur_dir) begin
            if (exp_io.size() == 0) fail("unexpected_io_word", int'(io_wdata));
            else chk("io_wdata", io_wdata, exp_io.pop_front());
          end
        end
        if (done) begin
          if (exp_done.size() == 0) fail("unexpected_done", 1);
          else begin
            void'(exp_done.pop_front());
            chk("hold_req_at_done", hold_req, 0);
            chk("busy_at_done", busy, 0);
          end
        end
      end
    end
  end

  // io device: level request, dropped the cycle after it sees io_ack.
  initial begin
    io_req = 1'b0;
    io_rdata = 8'd0;
    forever begin
      @(negedge clk);
      io_saw = io_ack;
      @(posedge clk);
      #1;
      if (!io_en) io_req = 1'b0;
      else if (io_saw) begin
        io_req = 1'b0;
        if (!cur_dir) io_rd++;
      end else if (!io_req && (cur_dir || io_rd < io_src.size()) && $urandom_range(0, 2) != 0) begin
        io_req = 1'b1;
        if (!cur_dir) io_rdata = io_src[io_rd];
      end
    end
  end

  // cpu grant: 0 = tied high, 1 = random grant/loss, 2 = scripted by man_ack.
  initial begin
    hold_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (gmode)
        0:       hold_ack = 1'b1;
        1:       hold_ack = hold_req && ($urandom_range(0, 3) != 0);
        default: hold_ack = man_ack;
      endcase
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    if (!m_busy) begin
      case (a)
        2'd0:    m_base = d;
        2'd1:    m_count = d;
        2'd2:    m_dir = d[1];
        default: ;
      endcase
    end
  endtask

  task automatic start(input bit dir);
    logic [7:0] a;
    logic [7:0] w;
    m_n = int'(m_count);
    cur_dir = dir;
    ack_base = io_ack_cnt;
    for (int i = 0; i < m_n; i++) begin
      a = m_base + 8'(i);
      if (!dir) begin
        w = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
        exp_wr.push_back({a, w});
        ref_mem[a] = w;
        io_src.push_back(w);
      end else begin
        exp_io.push_back(ref_mem[a]);
      end
    end
    exp_done.push_back(1'b1);
    io_en = 1'b1;
    cfg_write(2'd2, {6'd0, dir, 1'b1});
    m_busy = (m_n != 0);
    chk("busy_after_start", busy, m_n != 0);
    chk("hold_req_after_start", hold_req, m_n != 0);
    chk("done_after_start", done, m_n == 0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (exp_done.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (exp_done.size() != 0) begin
      fail("done_timeout_cycles", k);
      exp_done.delete();
    end
    tick();
    tick();
    chk("ram_writes_left", exp_wr.size(), 0);
    chk("io_words_left", exp_io.size(), 0);
    chk("io_ack_pulses", io_ack_cnt - ack_base, m_n);
    chk("hold_req_after_done", hold_req, 0);
    io_en = 1'b0;
    m_busy = 1'b0;
    tick();
    tick();
  endtask

  task automatic xfer(input logic [7:0] base, input logic [7:0] cnt, input bit dir);
    cfg_write(2'd0, base);
    cfg_write(2'd1, cnt);
    start(dir);
    wait_done(600);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hold_req", hold_req, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_w_notr", ram_w_notr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_io_ack", io_ack, 0);
    chk("rst_io_wdata", io_wdata, 0);
    rst = 1'b0;
    tick();

    // io->ram with known words
    fixed_q = '{8'hA1, 8'hA2, 8'hA3};
    xfer(8'h10, 8'd3, 1'b0);
    chk("ram_10", mem[8'h10], 8'hA1);
    chk("ram_11", mem[8'h11], 8'hA2);
    chk("ram_12", mem[8'h12], 8'hA3);

    // ram->io from preloaded 5C, 5D
    xfer(8'h20, 8'd2, 1'b1);

    // address wrap
    xfer(8'hFF, 8'd2, 1'b0);
    chk("ram_ff", mem[8'hFF], ref_mem[8'hFF]);
    chk("ram_00", mem[8'h00], ref_mem[8'h00]);

    // zero count: done only, no bus request
    cfg_write(2'd1, 8'd0);
    start(1'b0);
    tick();
    chk("zero_hold_req", hold_req, 0);
    chk("zero_done_one_cycle", done, 0);
    wait_done(10);

    // grant delayed then lost mid-block
    gmode = 2;
    man_ack = 1'b0;
    cfg_write(2'd0, 8'h60);
    cfg_write(2'd1, 8'd4);
    start(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold_req", hold_req, 1);
    end
    man_ack = 1'b1;
    repeat (4) tick();
    man_ack = 1'b0;
    repeat (3) tick();
    man_ack = 1'b1;
    wait_done(200);
    gmode = 0;

    // writes while busy are ignored; a later restart reuses the original BASE/COUNT
    cfg_write(2'd0, 8'h30);
    cfg_write(2'd1, 8'd4);
    start(1'b0);
    tick();
    tick();
    cfg_write(2'd0, 8'h40);
    cfg_write(2'd1, 8'd9);
    wait_done(200);
    start(1'b1);
    wait_done(200);

    // reset during the second word of a ram->io block
    cfg_write(2'd0, 8'h50);
    cfg_write(2'd1, 8'd4);
    start(1'b1);
    k = 0;
    while (io_ack_cnt == ack_base && k < 100) begin
      tick();
      k++;
    end
    chk("first_word_before_reset", io_ack_cnt - ack_base, 1);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hold_req", hold_req, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_ram_w_notr", ram_w_notr, 0);
    chk("midrst_ram_wdata", ram_wdata, 0);
    chk("midrst_io_ack", io_ack, 0);
    chk("midrst_io_wdata", io_wdata, 0);
    exp_io.delete();
    exp_done.delete();
    io_en = 1'b0;
    m_busy = 1'b0;
    m_base = 8'd0;
    m_count = 8'd0;
    m_dir = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    start(1'b0);
    wait_done(10);
    xfer(8'h70, 8'd3, 1'b0);

    // randomised blocks with random grant behaviour
    for (int t = 0; t < 20; t++) begin
      gmode = int'($urandom_range(0, 1));
      xfer(8'($urandom), 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end
    gmode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
